// File: rtl/mandelbrot_pkg.sv
// -----------------------------------------------------------------------------
// mandelbrot_pkg
// Shared definitions for the Mandelbrot frame engine:
//   - FSM state encoding (IDLE / ITER / HOLD)
//   - fixed-point format helper used by the escape-time ALU
//   - default viewport constants for the standard 640x480 view
// No ports (package).
// -----------------------------------------------------------------------------
package mandelbrot_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Fixed-point format: 3 integer bits (sign included), rest fraction.
    // This covers [-4, 4), enough for the |z| >= 2 escape test.
    localparam int INT_BITS = 3;

    function automatic int frac_bits(input int width);
        return width - INT_BITS;
    endfunction

    // Default viewport for a 640x480 frame at BITWIDTH=10 (Q3.7):
    // top-left corner at c = -2.0 - 1.25i, one LSB (1/128) per pixel,
    // which is the closest representable step to 3.0/640.
    localparam int DEFAULT_CR_START = -256;
    localparam int DEFAULT_CI_START = -160;
    localparam int DEFAULT_STEP     = 1;

endpackage

// File: rtl/mandelbrot_alu.sv
// -----------------------------------------------------------------------------
// mandelbrot_alu
// Combinational escape-time step: z_next = z^2 + c, plus an escape flag
// evaluated on the incoming z (size = |z|^2 >= 4).
// Fixed-point format: signed WIDTH bits, frac_bits(WIDTH) fraction bits.
// Ports:
//   zr, zi           current z (real, imaginary)
//   cr, ci           constant c (real, imaginary)
//   zr_next, zi_next z^2 + c, truncated and wrapped to WIDTH bits
//   size             |z|^2 >= 4.0 for the current z
// -----------------------------------------------------------------------------
module mandelbrot_alu
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] zr_next,
    output logic signed [WIDTH-1:0] zi_next,
    output logic                    size
);

    localparam int FRAC = frac_bits(WIDTH);
    localparam int PW   = 2 * WIDTH + 2;
    // 4.0 expressed in the squared (2*FRAC fraction bits) domain
    localparam logic signed [PW-1:0] ESC_LIMIT = PW'(4) <<< (2 * FRAC);

    logic signed [PW-1:0] zr_w, zi_w;
    logic signed [PW-1:0] rr, ii, ri;
    logic signed [PW-1:0] re_full, im_full, mag;
    logic                 unused_bits;

    assign zr_w = zr;
    assign zi_w = zi;

    assign rr = zr_w * zr_w;
    assign ii = zi_w * zi_w;
    assign ri = zr_w * zi_w;

    assign re_full = rr - ii;
    assign im_full = ri <<< 1;
    assign mag     = rr + ii;

    // Dropping FRAC low bits is an arithmetic shift; keeping WIDTH bits
    // then adding c wraps modulo 2^WIDTH (no saturation).
    assign zr_next = re_full[FRAC +: WIDTH] + cr;
    assign zi_next = im_full[FRAC +: WIDTH] + ci;
    assign size    = (mag >= ESC_LIMIT);

    // Truncated product bits are intentionally discarded.
    assign unused_bits = ^{re_full[PW-1:FRAC+WIDTH], re_full[FRAC-1:0],
                           im_full[PW-1:FRAC+WIDTH], im_full[FRAC-1:0]};

endmodule

// File: rtl/mandelbrot_frame.sv
// -----------------------------------------------------------------------------
// mandelbrot_frame
// Walks a programmable viewport in raster order, iterates every pixel through
// the shared escape-time ALU and streams (count, escaped, x, y, last) out on a
// valid/ready interface.
// Optional feature macro: MANDELBROT_JULIA_EN adds Julia mode (julia,
// julia_cr, julia_ci ports; z0 = pixel coordinate, c = latched julia_c).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin frame (IDLE only) / terminate frame
//   cr_start, ci_start    c at pixel (0,0)
//   step                  coordinate increment per pixel and per line
//   max_iter              iteration limit
//   julia, julia_cr/ci    Julia mode and constant (MANDELBROT_JULIA_EN only)
//   busy                  frame in progress
//   out_valid/out_ready   result stream handshake
//   out_count             iterations completed
//   out_escaped           pixel escaped
//   out_x, out_y, out_last pixel position, last pixel of the frame
//   done                  one-cycle pulse on normal frame completion
// -----------------------------------------------------------------------------
module mandelbrot_frame
    import mandelbrot_pkg::*;
#(
    parameter int BITWIDTH = 10,
    parameter int CTRWIDTH = 7,
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    localparam int XW = $clog2(H_PIXELS),
    localparam int YW = $clog2(V_PIXELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [BITWIDTH-1:0] cr_start,
    input  logic [BITWIDTH-1:0] ci_start,
    input  logic [BITWIDTH-1:0] step,
    input  logic [CTRWIDTH-1:0] max_iter,
`ifdef MANDELBROT_JULIA_EN
    input  logic                julia,
    input  logic [BITWIDTH-1:0] julia_cr,
    input  logic [BITWIDTH-1:0] julia_ci,
`endif
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CTRWIDTH-1:0] out_count,
    output logic                out_escaped,
    output logic [XW-1:0]       out_x,
    output logic [YW-1:0]       out_y,
    output logic                out_last,
    output logic                done
);

    logic [1:0]          state_reg, state_next;
    logic [XW-1:0]       x_reg;
    logic [YW-1:0]       y_reg;
    logic [BITWIDTH-1:0] cr_reg, ci_reg, zr_reg, zi_reg;
    logic [BITWIDTH-1:0] cr_start_reg, step_reg;
    logic [CTRWIDTH-1:0] ctr_reg, max_iter_reg, count_reg;
    logic                escaped_reg, done_reg;

    logic [BITWIDTH-1:0] zr_alu, zi_alu, c_r, c_i;
    logic [BITWIDTH-1:0] cr_adv, ci_adv;
    logic [BITWIDTH-1:0] z0r_start, z0i_start, z0r_adv, z0i_adv;
    logic                size, term, line_end, is_last;

    // ---------------- coordinate walker helpers ----------------
    assign line_end = (x_reg == XW'(H_PIXELS - 1));
    assign is_last  = line_end && (y_reg == YW'(V_PIXELS - 1));
    // Escape wins over the limit: size is captured as out_escaped either way.
    assign term     = size || (ctr_reg == max_iter_reg);

    // Coordinate of the next pixel; additions wrap modulo 2^BITWIDTH.
    assign cr_adv = line_end ? cr_start_reg : cr_reg + step_reg;
    assign ci_adv = line_end ? ci_reg + step_reg : ci_reg;

`ifdef MANDELBROT_JULIA_EN
    logic                julia_reg;
    logic [BITWIDTH-1:0] julia_cr_reg, julia_ci_reg;

    assign c_r = julia_reg ? julia_cr_reg : cr_reg;
    assign c_i = julia_reg ? julia_ci_reg : ci_reg;
    // At frame start the mode input is used directly: it is latched on the
    // same edge that loads z.
    assign z0r_start = julia ? cr_start : '0;
    assign z0i_start = julia ? ci_start : '0;
    assign z0r_adv   = julia_reg ? cr_adv : '0;
    assign z0i_adv   = julia_reg ? ci_adv : '0;
`else
    assign c_r       = cr_reg;
    assign c_i       = ci_reg;
    assign z0r_start = '0;
    assign z0i_start = '0;
    assign z0r_adv   = '0;
    assign z0i_adv   = '0;
`endif

    mandelbrot_alu #(
        .WIDTH (BITWIDTH)
    ) u_alu (
        .zr      (zr_reg),
        .zi      (zi_reg),
        .cr      (c_r),
        .ci      (c_i),
        .zr_next (zr_alu),
        .zi_next (zi_alu),
        .size    (size)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (start) state_next = ST_ITER;
                ST_ITER: if (term) state_next = ST_HOLD;
                ST_HOLD: if (out_ready) state_next = is_last ? ST_IDLE : ST_ITER;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_reg)
            ST_ITER: busy = 1'b1;
            ST_HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = is_last;
            end
            default: ;
        endcase
    end

    assign out_count   = count_reg;
    assign out_escaped = escaped_reg;
    assign out_x       = x_reg;
    assign out_y       = y_reg;
    assign done        = done_reg;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            cr_reg       <= '0;
            ci_reg       <= '0;
            zr_reg       <= '0;
            zi_reg       <= '0;
            cr_start_reg <= '0;
            step_reg     <= '0;
            max_iter_reg <= '0;
            ctr_reg      <= '0;
            count_reg    <= '0;
            escaped_reg  <= 1'b0;
            done_reg     <= 1'b0;
`ifdef MANDELBROT_JULIA_EN
            julia_reg    <= 1'b0;
            julia_cr_reg <= '0;
            julia_ci_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start && !abort) begin
                        cr_start_reg <= cr_start;
                        step_reg     <= step;
                        max_iter_reg <= max_iter;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        cr_reg       <= cr_start;
                        ci_reg       <= ci_start;
                        zr_reg       <= z0r_start;
                        zi_reg       <= z0i_start;
                        ctr_reg      <= '0;
`ifdef MANDELBROT_JULIA_EN
                        julia_reg    <= julia;
                        julia_cr_reg <= julia_cr;
                        julia_ci_reg <= julia_ci;
`endif
                    end
                end
                ST_ITER: begin
                    if (!abort) begin
                        if (term) begin
                            count_reg   <= ctr_reg;
                            escaped_reg <= size;
                        end else begin
                            zr_reg  <= zr_alu;
                            zi_reg  <= zi_alu;
                            ctr_reg <= ctr_reg + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!abort && out_ready) begin
                        if (is_last) begin
                            done_reg <= 1'b1;
                        end else begin
                            if (line_end) begin
                                x_reg <= '0;
                                y_reg <= y_reg + 1'b1;
                            end else begin
                                x_reg <= x_reg + 1'b1;
                            end
                            cr_reg  <= cr_adv;
                            ci_reg  <= ci_adv;
                            zr_reg  <= z0r_adv;
                            zi_reg  <= z0i_adv;
                            ctr_reg <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame.sv
// -----------------------------------------------------------------------------
// tb_mandelbrot_frame
// Self-checking bench for mandelbrot_frame on a 4x2 viewport. Expected pixel
// results come from a complex-arithmetic escape-time model on integers.
// Build with MANDELBROT_JULIA_EN defined to also exercise Julia mode.
// -----------------------------------------------------------------------------
module tb_mandelbrot_frame;

    localparam int BW   = 10;
    localparam int CW   = 7;
    localparam int H    = 4;
    localparam int V    = 2;
    localparam int NPIX = H * V;
    localparam int FRAC = BW - 3;
    localparam int XW   = $clog2(H);
    localparam int YW   = $clog2(V);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [BW-1:0] cr_start = '0, ci_start = '0, step = '0;
    logic [CW-1:0] max_iter = '0;
`ifdef MANDELBROT_JULIA_EN
    logic          julia = 1'b0;
    logic [BW-1:0] julia_cr = '0, julia_ci = '0;
`endif
    logic          busy, out_valid, out_escaped, out_last, done;
    logic [CW-1:0] out_count;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;

    always #5 clk = ~clk;

    mandelbrot_frame #(
        .BITWIDTH (BW),
        .CTRWIDTH (CW),
        .H_PIXELS (H),
        .V_PIXELS (V)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .cr_start    (cr_start),
        .ci_start    (ci_start),
        .step        (step),
        .max_iter    (max_iter),
`ifdef MANDELBROT_JULIA_EN
        .julia       (julia),
        .julia_cr    (julia_cr),
        .julia_ci    (julia_ci),
`endif
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_escaped (out_escaped),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_last    (out_last),
        .done        (done)
    );

    int checks = 0;
    int errors = 0;

    // expected and observed per-pixel results
    int exp_count [NPIX];
    int exp_esc   [NPIX];
    int res_count [64];
    int res_esc   [64];
    int res_x     [64];
    int res_y     [64];
    int res_last  [64];
    int nres, timed_out, done_cnt, done_cycle, done_busy, last_hs, first_valid, stable_bad;

    // ---------------- reference model ----------------
    function automatic longint wrapw(input longint v);
        longint m;
        m = v & longint'((1 << BW) - 1);
        if (m >= longint'(1 << (BW - 1))) m = m - longint'(1 << BW);
        return m;
    endfunction

    // Escape-time iteration on z (scaled by 2^FRAC), products truncated.
    function automatic void model_pixel(input longint zr0, input longint zi0,
                                        input longint cr, input longint ci,
                                        input int mi, output int cnt, output int esc);
        longint zr, zi, nr;
        int n;
        zr = zr0; zi = zi0; n = 0;
        cnt = 0; esc = 0;
        while (1) begin
            if (zr * zr + zi * zi >= (longint'(4) << (2 * FRAC))) begin
                cnt = n; esc = 1; return;
            end
            if (n == mi) begin
                cnt = n; esc = 0; return;
            end
            nr = wrapw(((zr * zr - zi * zi) >>> FRAC) + cr);
            zi = wrapw(((2 * zr * zi) >>> FRAC) + ci);
            zr = nr;
            n++;
        end
    endfunction

    function automatic void model_frame(input logic [BW-1:0] crs, input logic [BW-1:0] cis,
                                        input logic [BW-1:0] stp, input logic [CW-1:0] mi,
                                        input logic jul, input logic [BW-1:0] jcr,
                                        input logic [BW-1:0] jci);
        longint cr, ci;
        int c, e;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                cr = wrapw(longint'($signed(crs)) + x * longint'($signed(stp)));
                ci = wrapw(longint'($signed(cis)) + y * longint'($signed(stp)));
                if (jul)
                    model_pixel(cr, ci, longint'($signed(jcr)), longint'($signed(jci)), int'(mi), c, e);
                else
                    model_pixel(0, 0, cr, ci, int'(mi), c, e);
                exp_count[y * H + x] = c;
                exp_esc[y * H + x]   = e;
            end
        end
    endfunction

    // ---------------- frame driver / collector ----------------
    // Starts a frame and records every handshake. Cycle 1 is the first
    // cycle after the edge that samples start. stall_idx >= 0 holds
    // out_ready low for 5 valid cycles on that pixel and counts any payload
    // change into stable_bad.
    task automatic run_frame(input logic [BW-1:0] crs, input logic [BW-1:0] cis,
                             input logic [BW-1:0] stp, input logic [CW-1:0] mi,
                             input int ready_pct, input int stall_idx);
        int cyc, stall_left, h_count, h_esc, h_x, h_y;
        cr_start = crs; ci_start = cis; step = stp; max_iter = mi;
        start = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; nres = 0; timed_out = 0; done_cnt = 0; done_cycle = -1; done_busy = -1;
        last_hs = -1; first_valid = -1; stable_bad = 0; stall_left = 5;
        h_count = 0; h_esc = 0; h_x = 0; h_y = 0;
        while (1) begin
            if (cyc > 20000) begin timed_out = 1; break; end
            if (done) begin
                done_cnt = 1; done_cycle = cyc; done_busy = int'(busy); break;
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && nres == stall_idx && stall_left > 0) begin
                if (stall_left == 5) begin
                    h_count = int'(out_count); h_esc = int'(out_escaped);
                    h_x = int'(out_x); h_y = int'(out_y);
                end else if (int'(out_count) != h_count || int'(out_escaped) != h_esc ||
                             int'(out_x) != h_x || int'(out_y) != h_y) begin
                    stable_bad++;
                end
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            if (out_valid && out_ready) begin
                if (nres < 64) begin
                    res_count[nres] = int'(out_count); res_esc[nres] = int'(out_escaped);
                    res_x[nres] = int'(out_x); res_y[nres] = int'(out_y);
                    res_last[nres] = int'(out_last);
                end
                $display("txn %0d: x=%0d y=%0d count=%0d escaped=%0d last=%0d (cycle %0d)",
                         nres, out_x, out_y, out_count, out_escaped, out_last, cyc);
                nres++;
                last_hs = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (stall_idx >= 0 && stall_left != 0) stable_bad++;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if ({busy, out_valid, done, out_escaped, out_last, out_count, out_x, out_y} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b required all 0",
                     {busy, out_valid, done, out_escaped, out_last, out_count, out_x, out_y});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, out_valid, done, out_last} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: busy/valid/done/last=%b required 0000",
                     {busy, out_valid, done, out_last});
        end
    endtask

    // Directed views with expectations straight from the pixel rules:
    // 0: max_iter=0, 1: c=0 never escapes, 2: c far outside escapes at once.
    task automatic test_directed();
        logic [BW-1:0] crs, cis, stp;
        logic [CW-1:0] mi;
        int ec, ee, cost;
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin crs = BW'($urandom); cis = BW'($urandom); stp = BW'($urandom);
                         mi = 0; ec = 0; ee = 0; end
                1: begin crs = '0; cis = '0; stp = '0; mi = 15; ec = 15; ee = 0; end
                default: begin crs = BW'(384); cis = '0; stp = BW'(1);
                         mi = CW'($urandom_range(1, 127)); ec = 1; ee = 1; end
            endcase
            cost = (s == 2) ? 3 : int'(mi) + 2;
            run_frame(crs, cis, stp, mi, 100, -1);
            checks++;
            if (timed_out !== 0 || nres !== NPIX) begin
                errors++;
                $display("FAIL directed%0d_count: results=%0d timeout=%0d required %0d, 0",
                         s, nres, timed_out, NPIX);
            end
            for (int i = 0; i < NPIX && i < nres; i++) begin
                checks++;
                if (res_count[i] !== ec || res_esc[i] !== ee || res_x[i] !== i % H ||
                    res_y[i] !== i / H || res_last[i] !== int'(i == NPIX - 1)) begin
                    errors++;
                    $display("FAIL directed%0d_pix%0d: got c=%0d e=%0d (%0d,%0d) l=%0d required c=%0d e=%0d (%0d,%0d) l=%0d",
                             s, i, res_count[i], res_esc[i], res_x[i], res_y[i], res_last[i],
                             ec, ee, i % H, i / H, int'(i == NPIX - 1));
                end
            end
            checks++;
            if (first_valid !== cost || last_hs !== NPIX * cost) begin
                errors++;
                $display("FAIL directed%0d_timing: first_valid=%0d last_hs=%0d required %0d, %0d",
                         s, first_valid, last_hs, cost, NPIX * cost);
            end
            checks++;
            if (done_cnt !== 1 || done_cycle !== last_hs + 1 || done_busy !== 0) begin
                errors++;
                $display("FAIL directed%0d_done: pulses=%0d at %0d busy=%0d required 1 at %0d busy=0",
                         s, done_cnt, done_cycle, done_busy, last_hs + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [BW-1:0] crs, cis, stp;
        logic [CW-1:0] mi;
        int pct;
        for (int f = 0; f < 5; f++) begin
            crs = BW'($urandom); cis = BW'($urandom); stp = BW'($urandom_range(0, 40));
            mi = CW'($urandom_range(0, 30));
            pct = (f == 0) ? 100 : int'($urandom_range(30, 90));
            model_frame(crs, cis, stp, mi, 1'b0, '0, '0);
            run_frame(crs, cis, stp, mi, pct, -1);
            checks++;
            if (timed_out !== 0 || nres !== NPIX) begin
                errors++;
                $display("FAIL random%0d_count: results=%0d timeout=%0d required %0d, 0",
                         f, nres, timed_out, NPIX);
            end
            for (int i = 0; i < NPIX && i < nres; i++) begin
                checks++;
                if (res_count[i] !== exp_count[i] || res_esc[i] !== exp_esc[i] ||
                    res_x[i] !== i % H || res_y[i] !== i / H || res_last[i] !== int'(i == NPIX - 1)) begin
                    errors++;
                    $display("FAIL random%0d_pix%0d: got c=%0d e=%0d (%0d,%0d) l=%0d required c=%0d e=%0d (%0d,%0d)",
                             f, i, res_count[i], res_esc[i], res_x[i], res_y[i], res_last[i],
                             exp_count[i], exp_esc[i], i % H, i / H);
                end
            end
            checks++;
            if (done_cnt !== 1 || done_cycle !== last_hs + 1 || done_busy !== 0) begin
                errors++;
                $display("FAIL random%0d_done: pulses=%0d at %0d busy=%0d required 1 at %0d busy=0",
                         f, done_cnt, done_cycle, done_busy, last_hs + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] crs, cis, stp;
        logic [CW-1:0] mi;
        int sidx;
        crs = BW'($urandom); cis = BW'($urandom); stp = BW'($urandom_range(1, 30));
        mi = CW'($urandom_range(2, 20));
        sidx = int'($urandom_range(1, NPIX - 2));
        model_frame(crs, cis, stp, mi, 1'b0, '0, '0);
        run_frame(crs, cis, stp, mi, 100, sidx);
        checks++;
        if (stable_bad !== 0) begin
            errors++;
            $display("FAIL backpressure_stable: payload changes=%0d required 0 (pixel %0d)",
                     stable_bad, sidx);
        end
        checks++;
        if (timed_out !== 0 || nres !== NPIX) begin
            errors++;
            $display("FAIL backpressure_count: results=%0d required %0d", nres, NPIX);
        end
        for (int i = 0; i < NPIX && i < nres; i++) begin
            checks++;
            if (res_count[i] !== exp_count[i] || res_esc[i] !== exp_esc[i] ||
                res_x[i] !== i % H || res_y[i] !== i / H) begin
                errors++;
                $display("FAIL backpressure_pix%0d: got c=%0d e=%0d (%0d,%0d) required c=%0d e=%0d (%0d,%0d)",
                         i, res_count[i], res_esc[i], res_x[i], res_y[i],
                         exp_count[i], exp_esc[i], i % H, i / H);
            end
        end
    endtask

    task automatic test_abort();
        int hs, cyc, bad;
        logic [BW-1:0] crs, cis, stp;
        logic [CW-1:0] mi;
        cr_start = '0; ci_start = '0; step = '0; max_iter = 20;
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 3 && cyc < 2000) begin
            if (out_valid) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (hs !== 3 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_setup: handshakes=%0d busy=%b valid=%b required 3, 1, 0",
                     hs, busy, out_valid);
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_effect: busy=%b valid=%b required 0, 0", busy, out_valid);
        end
        bad = 0;
        repeat (30) begin
            if (done || out_valid || busy) bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL abort_quiet: active cycles after abort=%0d required 0", bad);
        end
        // restart must begin again at (0,0)
        crs = BW'($urandom); cis = BW'($urandom); stp = BW'($urandom_range(1, 30));
        mi = CW'($urandom_range(0, 20));
        model_frame(crs, cis, stp, mi, 1'b0, '0, '0);
        run_frame(crs, cis, stp, mi, 100, -1);
        checks++;
        if (timed_out !== 0 || nres !== NPIX || done_cnt !== 1) begin
            errors++;
            $display("FAIL abort_restart: results=%0d done=%0d required %0d, 1", nres, done_cnt, NPIX);
        end
        for (int i = 0; i < NPIX && i < nres; i++) begin
            checks++;
            if (res_count[i] !== exp_count[i] || res_esc[i] !== exp_esc[i] ||
                res_x[i] !== i % H || res_y[i] !== i / H) begin
                errors++;
                $display("FAIL abort_restart_pix%0d: got c=%0d e=%0d (%0d,%0d) required c=%0d e=%0d (%0d,%0d)",
                         i, res_count[i], res_esc[i], res_x[i], res_y[i],
                         exp_count[i], exp_esc[i], i % H, i / H);
            end
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b valid=%b required 0, 0", busy, out_valid);
        end
        @(posedge clk); #1;
    endtask

`ifdef MANDELBROT_JULIA_EN
    task automatic test_julia();
        logic [BW-1:0] crs, cis, stp;
        logic [CW-1:0] mi;
        for (int f = 0; f < 2; f++) begin
            julia = 1'b1;
            if (f == 0) begin
                julia_cr = '0; julia_ci = '0; crs = '0; cis = '0; stp = '0;
            end else begin
                julia_cr = BW'($urandom); julia_ci = BW'($urandom);
                crs = BW'($urandom); cis = BW'($urandom); stp = BW'($urandom_range(1, 30));
            end
            mi = CW'($urandom_range(1, 25));
            model_frame(crs, cis, stp, mi, 1'b1, julia_cr, julia_ci);
            if (f == 0) begin
                for (int i = 0; i < NPIX; i++) begin exp_count[i] = int'(mi); exp_esc[i] = 0; end
            end
            run_frame(crs, cis, stp, mi, 80, -1);
            julia = 1'b0;
            checks++;
            if (timed_out !== 0 || nres !== NPIX) begin
                errors++;
                $display("FAIL julia%0d_count: results=%0d required %0d", f, nres, NPIX);
            end
            for (int i = 0; i < NPIX && i < nres; i++) begin
                checks++;
                if (res_count[i] !== exp_count[i] || res_esc[i] !== exp_esc[i] ||
                    res_x[i] !== i % H || res_y[i] !== i / H) begin
                    errors++;
                    $display("FAIL julia%0d_pix%0d: got c=%0d e=%0d required c=%0d e=%0d",
                             f, i, res_count[i], res_esc[i], exp_count[i], exp_esc[i]);
                end
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        int hs, cyc;
        cr_start = '0; ci_start = '0; step = '0; max_iter = 20;
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hs = 0; cyc = 0;
        while (hs < 2 && cyc < 2000) begin
            if (out_valid) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out_x !== XW'(2) || out_count !== CW'(20)) begin
            errors++;
            $display("FAIL async_reset_setup: busy=%b x=%0d count=%0d required 1, 2, 20",
                     busy, out_x, out_count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, out_valid, done, out_escaped, out_last, out_count, out_x, out_y} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: outputs=%b required all 0",
                     {busy, out_valid, done, out_escaped, out_last, out_count, out_x, out_y});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame('0, '0, '0, '0, 100, -1);
        checks++;
        if (nres !== NPIX || done_cnt !== 1) begin
            errors++;
            $display("FAIL async_reset_recover: results=%0d done=%0d required %0d, 1",
                     nres, done_cnt, NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_abort();
        test_start_abort();
`ifdef MANDELBROT_JULIA_EN
        test_julia();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mandelbrot_frame.md
# mandelbrot_frame

Parametrised Mandelbrot frame engine. It walks a programmable viewport in raster order and iterates each pixel through the shared escape-time ALU. Each pixel's iteration count is returned on a valid/ready stream tagged with its coordinates. It sits between the host/control registers (viewport, iteration limit, start/abort) and the pixel sink (framebuffer writer or VGA colour mapper), which may apply backpressure.

## Interface
Parameters:
- BITWIDTH, 10: signed two's-complement width of c and z, in ALU fixed-point format
- CTRWIDTH, 7: iteration counter width
- H_PIXELS, 640: pixels per line
- V_PIXELS, 480: lines per frame
- XW / YW: $clog2(H_PIXELS) / $clog2(V_PIXELS); derived, not overridable

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  terminate frame immediately
- cr_start  in  BITWIDTH  real part of c at pixel (0,0)
- ci_start  in  BITWIDTH  imaginary part of c at pixel (0,0)
- step  in  BITWIDTH  coordinate increment per pixel and per line
- max_iter  in  CTRWIDTH  iteration limit
- julia_cr, julia_ci  in  BITWIDTH  fixed c in Julia mode; present only with MANDELBROT_JULIA_EN
- busy  out  1  frame in progress
- out_valid  out  1  result available
- out_ready  in  1  sink accepts the result
- out_count  out  CTRWIDTH  iterations completed
- out_escaped  out  1  pixel escaped before reaching max_iter
- out_x  out  XW  pixel column
- out_y  out  YW  pixel row
- out_last  out  1  result is pixel (H_PIXELS-1, V_PIXELS-1)
- done  out  1  one-cycle pulse when the frame completes normally

## Operation
- States: IDLE, ITER, HOLD. Reset enters IDLE. All outputs reset to 0.
- IDLE → ITER on start=1 and abort=0.
  - cr_start, ci_start, step and max_iter (plus julia_* when enabled) are latched.
  - x=0, y=0, cr=cr_start, ci=ci_start, z=0, ctr=0.
  - Inputs are ignored while busy.
- ITER, each cycle, with `size` the ALU escape flag evaluated on the current z:
  - size=1 or ctr==max_iter: capture out_count=ctr and out_escaped=size, then go to HOLD. If both hold, the result is still out_escaped=1.
  - Otherwise: z←ALU(z,c), ctr←ctr+1.
- HOLD: out_valid=1. The payload (count, escaped, x, y, last) stays stable until out_ready=1.
- On handshake, when the pixel is not the last:
  - If x==H_PIXELS-1: x←0, cr←latched cr_start, y←y+1, ci←ci+step. Otherwise: x←x+1, cr←cr+step.
  - z←0, ctr←0, go to ITER.
- On handshake of the last pixel: go to IDLE and pulse done.
- abort=1 in any state: go to IDLE next cycle, drop out_valid, no done pulse. The in-flight pixel is discarded.
- Arithmetic: cr/ci updates wrap modulo 2^BITWIDTH; there is no saturation. ctr never exceeds max_iter.
- max_iter=0: every pixel terminates on its first ITER cycle with count 0.
- busy=1 in ITER and HOLD.

## Timing
- start sampled at edge 0 → first ITER cycle is cycle 1, with ctr=k-1 in cycle k.
- Non-escaping pixel: out_valid first asserts at cycle max_iter+2.
- With out_ready held high, each pixel costs (iterations+2) cycles. The handshake cycle is followed directly by ITER.
- done is asserted in the cycle after the last handshake, together with busy=0.
- abort takes effect at the next edge: busy=0 and out_valid=0 one cycle after abort is sampled.
- rst_n is asynchronous: any state → IDLE and outputs → 0 immediately, mid-frame included.

## Configuration
- MANDELBROT_JULIA_EN defined:
  - Adds julia_cr/julia_ci ports and a mode input julia (1 bit, latched on start).
  - With julia=1: c=latched julia_c, z0=pixel coordinate. The pixel coordinate is loaded into z at frame start and on every pixel advance.
- Undefined: Mandelbrot only, with z0=0; the julia ports do not exist.

## Structure
- Package mandelbrot_pkg:
  - state encoding localparams (IDLE/ITER/HOLD)
  - default viewport constants: cr_start, ci_start and step for the standard 640×480 view
- Sub-module: instantiate the existing mandelbrot_alu (WIDTH=BITWIDTH) once. It is combinational: takes z, c and returns z² + c and `size`. There is no new sub-module.
- The coordinate walker (x/y/cr/ci) and the FSM stay in the top file.

## Test plan
- H=4, V=2, max_iter=0, out_ready=1: 8 results, count=0 and escaped=0 on all. (x,y) in order (0,0)…(3,1); out_last only on the 8th; done exactly once, one cycle later.
- step=0, cr/ci_start=0, max_iter=15: each pixel returns count=15, escaped=0. First out_valid at cycle 17 after start.
- c=cr_start far outside the set (escape on first iteration): count=1, escaped=1 for every pixel.
- out_ready held low 5 cycles during HOLD: out_valid and payload stable, x/y do not advance; handshake resumes the sequence without loss or duplication.
- abort in the middle of ITER on pixel 3: busy=0 and out_valid=0 one cycle later, no done. A following start restarts at (0,0). rst_n low mid-frame: all outputs 0 asynchronously.
- MANDELBROT_JULIA_EN, julia=1, julia_c=0, pixel coordinate 0: count=max_iter. With start and abort high together in IDLE: stays IDLE.
